// File: rtl/video_line_fetch_if.sv
// Memory read handshake between the scanline fetch controller and frame memory.
//   master (video_line_fetch): drives mem_req / mem_addr, samples mem_ack / mem_data
//   slave  (frame memory)    : samples mem_req / mem_addr, drives mem_ack / mem_data
//   mem_req  : read request, held until acked (may be withdrawn on a missed deadline)
//   mem_addr : word address, stable while mem_req is high
//   mem_ack  : read complete, mem_data valid in the same cycle
//   mem_data : {R,G,B} pixel word
interface video_line_fetch_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [23:0]           mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/video_line_fetch.sv
// Scanline fetch controller: fetches one low-resolution source line into a
// ping-pong line buffer ahead of display, then scales it horizontally and
// vertically onto the hdmi pixel outputs.
//   clk, reset            : pixel clock, asynchronous active-high reset
//   hpos, vpos            : current display column / line
//   in_hblank, in_vblank  : blanking from the video timing generator
//   mem                   : memory read handshake (master side)
//   red, green, blue      : registered pixel colour, one clock of latency
//   busy                  : fetch in progress
//   underrun              : sticky, a fetch was still running at its swap
module video_line_fetch #(
  parameter int SRC_WIDTH  = 160,
  parameter int SRC_HEIGHT = 240,
  parameter int H_SCALE    = 4,
  parameter int V_SCALE    = 2,
  parameter int FB_BASE    = 0,
  parameter int ADDR_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               in_hblank,
  input  logic               in_vblank,
  video_line_fetch_if.master mem,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               busy,
  output logic               underrun
);

  localparam int XW           = (SRC_WIDTH > 1) ? $clog2(SRC_WIDTH) : 1;
  localparam int LW           = (SRC_HEIGHT > 1) ? $clog2(SRC_HEIGHT) : 1;
  localparam int HS_LOG       = $clog2(H_SCALE);
  localparam int VS_LOG       = $clog2(V_SCALE);
  localparam int ACTIVE_COLS  = SRC_WIDTH * H_SCALE;
  localparam int ACTIVE_LINES = SRC_HEIGHT * V_SCALE;
  localparam logic [9:0]    V_MASK = 10'(V_SCALE - 1);
  localparam logic [XW-1:0] X_LAST = XW'(SRC_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t                state_q, state_d, state_eval;
  logic [XW-1:0]         x_q, x_d;
  logic [LW-1:0]         line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;
  logic                  underrun_q, underrun_d;
  logic                  disp_q, disp_d;
  logic                  hblank_q, hblank_d;
  logic                  vblank_q, vblank_d;
  logic [23:0]           rgb_q, rgb_d;

  logic                  active_start, vblank_start, row_aligned;
  logic                  swap, trig_line, abort, ack, wr_en;
  logic [9:0]            src_row;

  logic [23:0]           line_buf [2][SRC_WIDTH];

  always_comb begin
    hblank_d     = in_hblank;
    vblank_d     = in_vblank;
    active_start = hblank_q & ~in_hblank & ~in_vblank;
    vblank_start = ~vblank_q & in_vblank;
    src_row      = vpos >> VS_LOG;
    row_aligned  = (vpos & V_MASK) == 10'd0;
    swap         = active_start & row_aligned & (32'(vpos) < ACTIVE_LINES);
    trig_line    = active_start & row_aligned & ((32'(src_row) + 32'd1) < SRC_HEIGHT);
    // A swap while still fetching withdraws the request this very cycle, so
    // an ack arriving alongside it is not a completed read.
    abort        = swap & (state_q != IDLE);
    ack          = mem.mem_ack & req_q & ~abort;

    state_d    = state_q;
    x_d        = x_q;
    line_d     = line_q;
    disp_d     = disp_q ^ swap;
    underrun_d = underrun_q | abort;
    wr_en      = 1'b0;

    // Aborting returns to IDLE first so a coincident trigger can restart at once.
    state_eval = abort ? IDLE : state_q;
    if (state_eval == IDLE) begin
      state_d = IDLE;
      if (vblank_start) begin
        state_d = REQ;
        x_d     = '0;
        line_d  = '0;
      end else if (trig_line) begin
        state_d = REQ;
        x_d     = '0;
        line_d  = LW'(src_row + 10'd1);
      end
    end else if (ack) begin
      wr_en = 1'b1;
      if (x_q == X_LAST) begin
        state_d = IDLE;
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
    addr_d = ADDR_WIDTH'(FB_BASE) + ADDR_WIDTH'(line_d) * ADDR_WIDTH'(SRC_WIDTH)
           + ADDR_WIDTH'(x_d);

    // Read with the post-swap select so the first pixel of a new source line
    // already comes from the freshly filled buffer.
    rgb_d = '0;
    if (!in_hblank && !in_vblank && (32'(hpos) < ACTIVE_COLS) && (32'(vpos) < ACTIVE_LINES)) begin
      rgb_d = line_buf[disp_d][XW'(hpos >> HS_LOG)];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      disp_q     <= 1'b0;
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      disp_q     <= disp_d;
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      rgb_q      <= rgb_d;
    end
  end

  // Line buffers carry no reset; contents are undefined until refetched.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[~disp_q][x_q] <= mem.mem_data;
    end
  end

  assign mem.mem_req  = req_q & ~abort;
  assign mem.mem_addr = addr_q;
  assign red          = rgb_q[23:16];
  assign green        = rgb_q[15:8];
  assign blue         = rgb_q[7:0];
  assign busy         = busy_q;
  assign underrun     = underrun_q;

endmodule
